// File: rtl/port_strobe_receiver.sv
// Synchronizes the MCU run strobe and data bus, qualifies each strobe with a
// glitch filter, and queues one byte per strobe behind a valid/ready/tag port.
module port_strobe_receiver #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run_async,
  input  logic [DATA_WIDTH-1:0]    data_async,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_tag,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int CNT_MAX = (FILTER > SYNC_STAGES) ? FILTER : SYNC_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(FILTER - 1);
  localparam logic [CNT_W-1:0] SETTLE      = CNT_W'(SYNC_STAGES);
  localparam logic [LVL_W-1:0] FULL_LEVEL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE_LEVEL   = LVL_W'(1);

  typedef enum logic [1:0] {ARMED_WAIT, IDLE, HIGH} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   run_s;
  logic [DATA_WIDTH-1:0]  data_r;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   push;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       rd_ptr_next;
  logic                   pop;
  logic                   full;
  logic                   do_write;

  assign run_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      data_r <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], run_async};
      data_r <= data_async;
    end
  end

  // In ARMED_WAIT the counter first lets the cleared synchronizer refill, so a
  // strobe already high across reset release is seen as high and ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARMED_WAIT;
      cnt   <= '0;
    end else begin
      case (state)
        ARMED_WAIT: begin
          if (cnt != SETTLE) begin
            cnt <= cnt + 1'b1;
          end else if (!run_s) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        IDLE: begin
          if (!run_s) begin
            cnt <= '0;
          end else if (cnt == FILTER_LAST) begin
            state <= HIGH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!run_s) state <= IDLE;
        end
        default: begin
          state <= ARMED_WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign push        = (state == IDLE) && run_s && (cnt == FILTER_LAST);
  assign pop         = out_valid && out_ready;
  assign full        = (level == FULL_LEVEL);
  assign do_write    = push && (!full || pop);
  assign rd_ptr_next = rd_ptr + 1'b1;

  always_ff @(posedge clock) begin
    if (do_write) mem[wr_ptr] <= data_r;
  end

  // The output register is prefetched on pop so the next word appears right
  // after the pop edge; a word pushed into an empty queue shows up one edge later.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_tag   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;

      case ({do_write, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (pop) begin
        rd_ptr    <= rd_ptr_next;
        out_tag   <= ~out_tag;
        out_valid <= (level != ONE_LEVEL);
        if (level != ONE_LEVEL) out_data <= mem[rd_ptr_next];
      end else if (!out_valid && (level != '0)) begin
        out_valid <= 1'b1;
        out_data  <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_port_strobe_receiver.sv
// Directed bench for port_strobe_receiver: latency, glitch filter, overflow,
// push/pop at full, wrap-around and reset during a strobe.
module tb_port_strobe_receiver;

  logic       clock = 1'b0;
  logic       reset;
  logic       run_async;
  logic [7:0] data_async;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_tag;
  logic [2:0] level;
  logic       overflow;

  int tests_run    = 0;
  int tests_failed = 0;
  logic exp_tag;

  port_strobe_receiver dut (
    .clock      (clock),
    .reset      (reset),
    .run_async  (run_async),
    .data_async (data_async),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tag    (out_tag),
    .level      (level),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int hi, input int lo);
    data_async = d;
    run_async  = 1'b1;
    tick(hi);
    run_async  = 1'b0;
    tick(lo);
  endtask

  task automatic popOne(input string tag, input logic [7:0] expected);
    checkOutput({tag, "_data"}, out_data, expected);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    exp_tag   = ~exp_tag;
    checkOutput({tag, "_tag"}, out_tag, exp_tag);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick(2);
    reset   = 1'b0;
    exp_tag = 1'b0;
    tick(4);
  endtask

  logic [7:0] got[$];
  int         toggles;
  logic       prev_tag;

  initial begin
    reset      = 1'b1;
    run_async  = 1'b0;
    data_async = 8'h00;
    out_ready  = 1'b0;
    exp_tag    = 1'b0;
    tick(3);
    checkOutput("rst_data",     out_data,  8'h00);
    checkOutput("rst_valid",    out_valid, 1'b0);
    checkOutput("rst_tag",      out_tag,   1'b0);
    checkOutput("rst_level",    level,     3'd0);
    checkOutput("rst_overflow", overflow,  1'b0);
    reset = 1'b0;
    tick(4);

    // single word and latency
    data_async = 8'h5A;
    run_async  = 1'b1;
    tick(4);
    checkOutput("lat_valid_early", out_valid, 1'b0);
    tick(1);
    checkOutput("lat_valid", out_valid, 1'b1);
    checkOutput("lat_data",  out_data,  8'h5A);
    checkOutput("lat_level", level,     3'd1);
    tick(3);
    run_async = 1'b0;
    tick(6);
    popOne("single", 8'h5A);
    checkOutput("single_valid_after", out_valid, 1'b0);
    checkOutput("single_level_after", level,     3'd0);

    // glitch rejection, then a long strobe
    data_async = 8'hC3;
    run_async  = 1'b1;
    tick(1);
    run_async  = 1'b0;
    tick(8);
    checkOutput("glitch_level", level,     3'd0);
    checkOutput("glitch_valid", out_valid, 1'b0);
    applyStimulus(8'h77, 20, 6);
    checkOutput("long_level", level, 3'd1);
    popOne("long", 8'h77);
    checkOutput("long_level_after", level, 3'd0);

    // fill and overflow
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 6, 6);
    checkOutput("fill_level",    level,    3'd4);
    checkOutput("fill_overflow", overflow, 1'b1);
    for (int i = 1; i <= 4; i++) popOne($sformatf("drain%0d", i), 8'(i));
    checkOutput("drain_valid",    out_valid, 1'b0);
    checkOutput("drain_overflow", overflow,  1'b1);

    // simultaneous push and pop while full
    doReset();
    checkOutput("rst2_overflow", overflow, 1'b0);
    for (int i = 1; i <= 4; i++) applyStimulus(8'h20 + 8'(i), 6, 6);
    checkOutput("full_level", level, 3'd4);
    data_async = 8'h25;
    run_async  = 1'b1;
    tick(3);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    exp_tag   = ~exp_tag;
    checkOutput("pp_level",    level,    3'd4);
    checkOutput("pp_overflow", overflow, 1'b0);
    checkOutput("pp_data",     out_data, 8'h22);
    checkOutput("pp_tag",      out_tag,  exp_tag);
    tick(3);
    run_async = 1'b0;
    tick(6);
    for (int i = 2; i <= 5; i++) popOne($sformatf("pp_out%0d", i), 8'h20 + 8'(i));
    checkOutput("pp_level_after", level, 3'd0);

    // wrap-around with a consumer that is ready every other clock
    got.delete();
    toggles  = 0;
    prev_tag = out_tag;
    fork
      begin
        for (int i = 0; i < 10; i++) applyStimulus(8'h10 + 8'(i), 6, 6);
      end
      begin
        for (int c = 0; c < 160; c++) begin
          out_ready = (c % 2 == 1);
          if (out_valid && out_ready) got.push_back(out_data);
          tick(1);
          if (out_tag != prev_tag) begin
            toggles++;
            prev_tag = out_tag;
          end
        end
        out_ready = 1'b0;
      end
    join
    checkOutput("wrap_count",   got.size(), 10);
    checkOutput("wrap_toggles", toggles,    10);
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("wrap_word%0d", i),
                  (i < got.size()) ? {24'd0, got[i]} : 32'hDEAD, 8'h10 + 8'(i));
    checkOutput("wrap_overflow", overflow, 1'b0);
    checkOutput("wrap_level",    level,    3'd0);

    // reset while a strobe is high with two words queued
    applyStimulus(8'h31, 6, 6);
    applyStimulus(8'h32, 6, 6);
    checkOutput("mid_level_before", level, 3'd2);
    data_async = 8'h99;
    run_async  = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(2);
    checkOutput("mid_rst_data",     out_data,  8'h00);
    checkOutput("mid_rst_valid",    out_valid, 1'b0);
    checkOutput("mid_rst_tag",      out_tag,   1'b0);
    checkOutput("mid_rst_level",    level,     3'd0);
    checkOutput("mid_rst_overflow", overflow,  1'b0);
    reset = 1'b0;
    tick(12);
    checkOutput("mid_held_level", level,     3'd0);
    checkOutput("mid_held_valid", out_valid, 1'b0);
    run_async = 1'b0;
    tick(6);
    applyStimulus(8'h33, 6, 6);
    checkOutput("mid_next_level", level,    3'd1);
    checkOutput("mid_next_data",  out_data, 8'h33);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
